// File: rtl/kan_ram_pkg.sv
// Shared definitions for the kernel RAM read path.
//   KAN_PTR_WIDTH  : default RAM address width (words = 2**KAN_PTR_WIDTH)
//   KAN_DATA_WIDTH : default RAM word width
//   KAN_LEN_WIDTH  : default burst length width (must hold 2**KAN_PTR_WIDTH)
//   rd_state_e     : reader controller states
package kan_ram_pkg;

  localparam int KAN_PTR_WIDTH  = 12;
  localparam int KAN_DATA_WIDTH = 128;
  localparam int KAN_LEN_WIDTH  = KAN_PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/kernel_ram_reader_stream_fifo2.sv
// stream_fifo2: two-entry FIFO carrying {data, last}. Entry 0 is always the
// head, so the output is a plain register read with no read pointer mux.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write data_i/last_i (caller guarantees not full unless popping)
//   pop_i      : drop head (caller guarantees not empty)
//   data_o     : head data
//   last_o     : head last flag
//   occ_o      : occupancy 0..2
module stream_fifo2
  import kan_ram_pkg::*;
#(
  parameter int DATA_WIDTH = KAN_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic                  l0_q, l0_d, l1_q, l1_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    d0_d  = d0_q;
    l0_d  = l0_q;
    d1_d  = d1_q;
    l1_d  = l1_q;
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) begin
          d0_d = data_i;
          l0_d = last_i;
        end else begin
          d1_d = data_i;
          l1_d = last_i;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        l0_d  = l1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // occupancy unchanged; new word goes behind whatever survives the pop
        if (occ_q == 2'd2) begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = data_i;
          l1_d = last_i;
        end else begin
          d0_d = data_i;
          l0_d = last_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q  <= '0;
      l0_q  <= 1'b0;
      d1_q  <= '0;
      l1_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      d0_q  <= d0_d;
      l0_q  <= l0_d;
      d1_q  <= d1_d;
      l1_q  <= l1_d;
      occ_q <= occ_d;
    end
  end

  assign data_o = d0_q;
  assign last_o = l0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/kernel_ram_reader.sv
// kernel_ram_reader: turns a start/base/length command into reads on the
// kernel RAM read port (1-cycle latency) and presents the words as a
// valid/ready stream with a last marker.
//   clk, rst              : clock, synchronous active-high reset
//   start/base_addr/length: command, accepted only in IDLE
//   busy, done            : burst in progress / 1-cycle completion pulse
//   ram_ren/ram_addrb     : RAM read request
//   ram_dob               : RAM read data, valid the cycle after ram_ren
//   m_valid/m_ready/m_data/m_last : output stream
//
// state | meaning
// IDLE  | waiting for start; length 0 just pulses done
// RUN   | issuing reads as output credit allows
// DRAIN | all reads issued, waiting for the last word handshake
module kernel_ram_reader
  import kan_ram_pkg::*;
#(
  parameter int PTR_WIDTH  = KAN_PTR_WIDTH,
  parameter int DATA_WIDTH = KAN_DATA_WIDTH,
  parameter int LEN_WIDTH  = KAN_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PTR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ren,
  output logic [PTR_WIDTH-1:0]  ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  rd_state_e             state_q, state_d;
  logic [PTR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issue_rem_q, issue_rem_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_last_q;
  logic                  issue, pop;
  logic [1:0]            occ;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic [2:0]            credit_used, credit_lim;

  assign pop = m_valid & m_ready;

  // Words stored plus the word on ram_dob must stay below the FIFO depth
  // after this cycle's pop, so a new read always has a slot when it lands.
  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
  assign credit_lim  = 3'd2 + {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_rem_d = issue_rem_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d      = base_addr;
            issue_rem_d = length;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if ((issue_rem_q != '0) && (credit_used < credit_lim)) begin
          issue       = 1'b1;
          addr_d      = addr_q + PTR_WIDTH'(1);
          issue_rem_d = issue_rem_q - LEN_WIDTH'(1);
          if (issue_rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      issue_rem_q     <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      issue_rem_q     <= issue_rem_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_rem_q == LEN_WIDTH'(1));
    end
  end

  stream_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i (ram_dob),
    .last_i (inflight_last_q),
    .data_o (head_data),
    .last_o (head_last),
    .occ_o  (occ)
  );

  assign ram_ren   = issue;
  assign ram_addrb = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = head_data;
  // entry 0 can hold a stale flag after the last pop; only meaningful when valid
  assign m_last    = head_last & m_valid;

endmodule
